// File: rtl/is_pkg_uart_controller.sv
`default_nettype none
// ============================================================================
// Module      : is_pkg_uart_controller
// Description : Shared definitions for the UART controller. RATIO is the
//               number of oversampling enable pulses per bit, common to the
//               RX and TX paths. Also holds the TX state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package is_pkg_uart_controller;

  // Oversampling pulses per bit period; must be a power of two >= 2 so the
  // sample counter wraps naturally.
  localparam int RATIO = 8;
  localparam int CNT_W = $clog2(RATIO);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/is_uart_cnt_samp_tx.sv
`default_nettype none
// ============================================================================
// Module      : is_uart_cnt_samp_tx
// Description : TX sample counter. Counts oversampling enable pulses and
//               flags the pulse that closes a bit period.
// Ports       : clk_i     - system clock
//               rstn_i    - asynchronous active-low reset
//               uart_ce_i - oversampling enable (RATIO pulses per bit)
//               clear_i   - holds the counter at 0 (idle / frame accept)
//               tx_ce_o   - one-cycle bit-period strobe
// Revision    : 1.0 - initial release
// ============================================================================
module is_uart_cnt_samp_tx
  import is_pkg_uart_controller::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic uart_ce_i,
  input  logic clear_i,
  output logic tx_ce_o
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] r_cnt;

  // RATIO is a power of two, so the increment past C_CNT_LAST wraps to 0 on
  // the same edge that raises the bit strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (uart_ce_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tx_ce_o = uart_ce_i && !clear_i && (r_cnt == C_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/is_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : is_uart_tx
// Description : UART transmitter. Accepts a byte over valid/ready, frames it
//               as start, LSB-first data, optional parity and 1 or 2 stop
//               bits, and drives a registered serial line.
// Ports       : clk_i      - system clock
//               rstn_i     - asynchronous active-low reset
//               uart_ce_i  - oversampling enable (RATIO pulses per bit)
//               tx_data_i  - byte to send, captured on accept
//               tx_valid_i - tx_data_i valid
//               tx_ready_o - ready to accept (idle)
//               tx_o       - serial line, idle high
//               tx_busy_o  - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module is_uart_tx
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              uart_ce_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              tx_busy_o
);

  localparam int                IDX_W       = $clog2(DATA_W) + 1;
  localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic              C_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              C_ODD       = (PARITY_ODD != 0);

  tx_state_t         r_state, w_state_d;
  logic [DATA_W-1:0] r_shift, w_shift_d;
  logic [DATA_W-1:0] r_data,  w_data_d;
  logic [IDX_W-1:0]  r_idx,   w_idx_d;
  logic              r_stop,  w_stop_d;
  logic              r_tx,    w_tx_d;
  logic              w_bit_ce;
  logic              w_idle;
  logic              w_parity;

  assign w_idle   = (r_state == TX_IDLE);
  // Parity comes from the copy latched at accept; the shift register is
  // already emptied by the time the parity bit goes out.
  assign w_parity = (^r_data) ^ C_ODD;

  is_uart_cnt_samp_tx u_cnt (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .uart_ce_i (uart_ce_i),
    .clear_i   (w_idle),
    .tx_ce_o   (w_bit_ce)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= TX_IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_data  <= w_data_d;
      r_idx   <= w_idx_d;
      r_stop  <= w_stop_d;
      r_tx    <= w_tx_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_data_d  = r_data;
    w_idx_d   = r_idx;
    w_stop_d  = r_stop;
    w_tx_d    = 1'b1;

    case (r_state)
      TX_IDLE: begin
        if (tx_valid_i) begin
          w_state_d = TX_START;
          w_shift_d = tx_data_i;
          w_data_d  = tx_data_i;
          w_idx_d   = '0;
          w_stop_d  = 1'b0;
        end
      end
      TX_START: begin
        if (w_bit_ce) begin
          w_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_bit_ce) begin
          w_shift_d = r_shift >> 1;
          w_idx_d   = r_idx + 1'b1;
          if (r_idx == C_IDX_LAST) begin
            w_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        if (w_bit_ce) begin
          w_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_bit_ce) begin
          if (r_stop == C_STOP_LAST) begin
            w_state_d = TX_IDLE;
          end else begin
            w_stop_d = r_stop + 1'b1;
          end
        end
      end
      default: w_state_d = TX_IDLE;
    endcase

    // Line level is derived from the next state so the registered output
    // changes on the same edge as the state.
    case (w_state_d)
      TX_START:  w_tx_d = 1'b0;
      TX_DATA:   w_tx_d = w_shift_d[0];
      TX_PARITY: w_tx_d = w_parity;
      default:   w_tx_d = 1'b1;
    endcase
  end

  assign tx_o       = r_tx;
  assign tx_ready_o = w_idle;
  assign tx_busy_o  = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_is_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_is_uart_tx
// Description : Directed self-checking bench for is_uart_tx. Four instances
//               cover 8N1, 8E1, 8O1 and 8N2 framing (RATIO = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_is_uart_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       uart_ce;
  logic [7:0] tx_data;
  logic [3:0] tx_valid;
  logic [3:0] tx_ready;
  logic [3:0] tx_line;
  logic [3:0] tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit sparse   = 1'b0;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  is_uart_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk_i(clk), .rstn_i(rstn), .uart_ce_i(uart_ce), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]), .tx_o(tx_line[0]),
    .tx_busy_o(tx_busy[0]));
  is_uart_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk_i(clk), .rstn_i(rstn), .uart_ce_i(uart_ce), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]), .tx_o(tx_line[1]),
    .tx_busy_o(tx_busy[1]));
  is_uart_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk_i(clk), .rstn_i(rstn), .uart_ce_i(uart_ce), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[2]), .tx_ready_o(tx_ready[2]), .tx_o(tx_line[2]),
    .tx_busy_o(tx_busy[2]));
  is_uart_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk_i(clk), .rstn_i(rstn), .uart_ce_i(uart_ce), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid[3]), .tx_ready_o(tx_ready[3]), .tx_o(tx_line[3]),
    .tx_busy_o(tx_busy[3]));

  // Advance to the next falling edge and set up the enable for the next
  // rising edge: always high, or high every 4th clock in sparse mode.
  task automatic tick();
    @(negedge clk);
    cyc++;
    uart_ce = sparse ? (cyc % 4 == 0) : 1'b1;
  endtask

  task automatic start_frame(input int d, input logic [7:0] value);
    tx_data     = value;
    tx_valid[d] = 1'b1;
    tick();
    tx_valid[d] = 1'b0;
  endtask

  // Records the line level at the first clock of each bit, whether every bit
  // held its level for exactly cpb clocks, and whether ready/busy stayed
  // in the busy state throughout. Ends on the clock after the frame.
  task automatic capture(input int d, input int nbits, input int cpb,
                         output logic [10:0] bits, output bit stable,
                         output bit busy_ok);
    bits    = '1;
    stable  = 1'b1;
    busy_ok = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < cpb; k++) begin
        if (k == 0) bits[b] = tx_line[d];
        else if (tx_line[d] !== bits[b]) stable = 1'b0;
        if (tx_ready[d] !== 1'b0 || tx_busy[d] !== 1'b1) busy_ok = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rstn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({tx_line, tx_ready, tx_busy} !== {4'hF, 4'hF, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_values: got line=%h ready=%h busy=%h, expected F F 0",
               tx_line, tx_ready, tx_busy);
    end
    rstn = 1'b1;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({tx_line, tx_ready, tx_busy} !== {4'hF, 4'hF, 4'h0}) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d bad idle clocks, expected 0", bad);
    end
  endtask

  task automatic test_basic_frame();
    logic [10:0] bits;
    bit stable, busy_ok;
    start_frame(0, 8'hA5);
    n_checks++;
    if ({tx_line[0], tx_ready[0], tx_busy[0]} !== 3'b001) begin
      n_fail++;
      $display("FAIL accept_latency: got tx/ready/busy=%b, expected 001",
               {tx_line[0], tx_ready[0], tx_busy[0]});
    end
    capture(0, 10, 8, bits, stable, busy_ok);
    n_checks++;
    if (bits !== 11'b111_0100_1010) begin
      n_fail++;
      $display("FAIL basic_bits: got %b expected %b", bits, 11'b111_0100_1010);
    end
    n_checks++;
    if (!stable || !busy_ok) begin
      n_fail++;
      $display("FAIL basic_timing: stable=%0d busy=%0d, expected 1 1", stable, busy_ok);
    end
    n_checks++;
    if ({tx_ready[0], tx_line[0], tx_busy[0]} !== 3'b110) begin
      n_fail++;
      $display("FAIL basic_idle: got ready/tx/busy=%b expected 110",
               {tx_ready[0], tx_line[0], tx_busy[0]});
    end
  endtask

  task automatic test_parity();
    // dut, data, expected frame {stop, parity, data, start}
    int          dut [3] = '{1, 1, 2};
    logic [7:0]  dat [3] = '{8'h07, 8'hA5, 8'hA5};
    logic [10:0] exp [3] = '{{1'b1, 1'b1, 8'h07, 1'b0},
                             {1'b1, 1'b0, 8'hA5, 1'b0},
                             {1'b1, 1'b1, 8'hA5, 1'b0}};
    logic [10:0] bits;
    bit stable, busy_ok;
    for (int t = 0; t < 3; t++) begin
      start_frame(dut[t], dat[t]);
      capture(dut[t], 11, 8, bits, stable, busy_ok);
      n_checks++;
      if (bits !== exp[t] || !stable || !busy_ok) begin
        n_fail++;
        $display("FAIL parity_%0d: got %b stable=%0d busy=%0d expected %b 1 1",
                 t, bits, stable, busy_ok, exp[t]);
      end
      n_checks++;
      if (tx_ready[dut[t]] !== 1'b1) begin
        n_fail++;
        $display("FAIL parity_idle_%0d: got ready=%b expected 1", t, tx_ready[dut[t]]);
      end
    end
  endtask

  task automatic test_sparse_ce();
    logic [10:0] bits;
    bit stable, busy_ok;
    sparse = 1'b1;
    while (cyc % 4 != 0) tick();
    start_frame(0, 8'h3C);
    capture(0, 10, 32, bits, stable, busy_ok);
    n_checks++;
    if (bits !== {1'b1, 1'b1, 8'h3C, 1'b0} || !stable || !busy_ok) begin
      n_fail++;
      $display("FAIL sparse_frame: got %b stable=%0d busy=%0d expected %b 1 1",
               bits, stable, busy_ok, {1'b1, 1'b1, 8'h3C, 1'b0});
    end
    n_checks++;
    if (tx_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sparse_idle: got ready=%b expected 1", tx_ready[0]);
    end
    sparse = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    bit stable, busy_ok;
    tx_data     = 8'h00;
    tx_valid[3] = 1'b1;
    tick();
    tx_data = 8'hFF;               // changes while the 0x00 frame is in flight
    capture(3, 11, 8, bits, stable, busy_ok);
    n_checks++;
    if (bits !== {2'b11, 8'h00, 1'b0} || !stable || !busy_ok) begin
      n_fail++;
      $display("FAIL b2b_first: got %b stable=%0d busy=%0d expected %b 1 1",
               bits, stable, busy_ok, {2'b11, 8'h00, 1'b0});
    end
    n_checks++;
    if ({tx_ready[3], tx_line[3]} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_gap: got ready/tx=%b expected 11", {tx_ready[3], tx_line[3]});
    end
    tick();
    tx_valid[3] = 1'b0;
    capture(3, 11, 8, bits, stable, busy_ok);
    n_checks++;
    if (bits !== {2'b11, 8'hFF, 1'b0} || !stable || !busy_ok) begin
      n_fail++;
      $display("FAIL b2b_second: got %b stable=%0d busy=%0d expected %b 1 1",
               bits, stable, busy_ok, {2'b11, 8'hFF, 1'b0});
    end
    n_checks++;
    if (tx_ready[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: got ready=%b expected 1", tx_ready[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    bit stable, busy_ok;
    start_frame(0, 8'h00);
    repeat (36) tick();            // middle of data bit 3
    n_checks++;
    if ({tx_line[0], tx_busy[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL midframe_pre: got tx/busy=%b expected 01", {tx_line[0], tx_busy[0]});
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({tx_line[0], tx_ready[0], tx_busy[0]} !== 3'b110) begin
      n_fail++;
      $display("FAIL midframe_async: got tx/ready/busy=%b expected 110",
               {tx_line[0], tx_ready[0], tx_busy[0]});
    end
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    start_frame(0, 8'h55);
    capture(0, 10, 8, bits, stable, busy_ok);
    n_checks++;
    if (bits !== {1'b1, 1'b1, 8'h55, 1'b0} || !stable || !busy_ok) begin
      n_fail++;
      $display("FAIL midframe_fresh: got %b stable=%0d busy=%0d expected %b 1 1",
               bits, stable, busy_ok, {1'b1, 1'b1, 8'h55, 1'b0});
    end
  endtask

  initial begin
    rstn     = 1'b0;
    uart_ce  = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 4'h0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_sparse_ce();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
